network_sink: RTL and testbench

NETWORK_SINK -- requirements
Module: network_sink

---
 rtl/network_sink.sv | 127 ++++++++++++
 tb/tb_network_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/network_sink.sv
// Spike sink: turns a network step's fire vector into a stream of SPK/TCK packets,
// and answers decode requests with a DEC packet carrying the step count.
package network_config;
    localparam int NET_NUM_OUT = 4;
endpackage

package sink_config;
    import network_config::*;
    localparam int CNT_WIDTH = 16;
    localparam int IDX_WIDTH = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1;
    localparam int PAY_WIDTH = (IDX_WIDTH > CNT_WIDTH) ? IDX_WIDTH : CNT_WIDTH;
    localparam int SNK_WIDTH = 2 + PAY_WIDTH;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_SPK = 2'd1;
    localparam logic [1:0] OP_TCK = 2'd2;
    localparam logic [1:0] OP_DEC = 2'd3;
endpackage

module network_sink
    import network_config::*;
    import sink_config::IDX_WIDTH, sink_config::OP_SPK, sink_config::OP_TCK, sink_config::OP_DEC;
#(
    parameter int CNT_WIDTH = 16,
    localparam int PAY_W = (IDX_WIDTH > CNT_WIDTH) ? IDX_WIDTH : CNT_WIDTH,
    localparam int SNK_W = 2 + PAY_W
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   net_out_valid,
    input  logic [NET_NUM_OUT-1:0] net_out,
    output logic                   sink_ready,
    input  logic                   dec_req,
    output logic                   snk_valid,
    input  logic                   snk_ready,
    output logic [SNK_W-1:0]       snk
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_TCK, S_DEC} state_e;

    state_e                 state_q, state_d;
    logic [NET_NUM_OUT-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]   step_cnt_q, step_cnt_d;
    logic                   dec_pend_q, dec_pend_d;
    logic                   snk_valid_q;
    logic [SNK_W-1:0]       snk_q, pkt_d;
    logic                   load, load_ok;

    function automatic logic [IDX_WIDTH-1:0] lowest_idx(input logic [NET_NUM_OUT-1:0] m);
        lowest_idx = '0;
        for (int i = NET_NUM_OUT - 1; i >= 0; i--)
            if (m[i]) lowest_idx = IDX_WIDTH'(i);
    endfunction

    assign sink_ready = (state_q == S_IDLE) && !dec_pend_q;
    assign load_ok    = !snk_valid_q || snk_ready;
    assign snk_valid  = snk_valid_q;
    assign snk        = snk_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        step_cnt_d = step_cnt_q;
        dec_pend_d = dec_pend_q;
        load       = 1'b0;
        pkt_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (dec_pend_q) begin
                    state_d = S_DEC;
                end else if (net_out_valid) begin
                    mask_d  = net_out;
                    state_d = (|net_out) ? S_SCAN : S_TCK;
                end
            end
            S_SCAN: if (load_ok) begin
                load  = 1'b1;
                pkt_d = {OP_SPK, PAY_W'(lowest_idx(mask_q))};
                // m & (m-1) drops exactly the lowest set bit
                mask_d = mask_q & (mask_q - NET_NUM_OUT'(1));
                if (mask_d == '0) state_d = S_TCK;
            end
            S_TCK: if (load_ok) begin
                load  = 1'b1;
                pkt_d = {OP_TCK, {PAY_W{1'b0}}};
                if (step_cnt_q != {CNT_WIDTH{1'b1}}) step_cnt_d = step_cnt_q + CNT_WIDTH'(1);
                state_d = S_IDLE;
            end
            S_DEC: if (load_ok) begin
                load       = 1'b1;
                pkt_d      = {OP_DEC, PAY_W'(step_cnt_q)};
                step_cnt_d = '0;
                dec_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a request landing in the DEC load cycle is kept, so it is never lost
        if (dec_req) dec_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            step_cnt_q <= '0;
            dec_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            step_cnt_q <= step_cnt_d;
            dec_pend_q <= dec_pend_d;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            snk_valid_q <= 1'b0;
            snk_q       <= '0;
        end else if (load) begin
            snk_valid_q <= 1'b1;
            snk_q       <= pkt_d;
        end else if (snk_ready) begin
            snk_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_network_sink.sv
// Scoreboard bench for network_sink: a step-level model queues the expected packet
// stream; an independent monitor pops and compares on every accepted packet.
module tb_network_sink;
    import network_config::*;

    localparam int CW   = 8;
    localparam int PW   = 8;
    localparam int SW   = 2 + PW;
    localparam int CMAX = (1 << CW) - 1;

    logic                   clk = 1'b0;
    logic                   arstn = 1'b0;
    logic                   net_out_valid = 1'b0;
    logic [NET_NUM_OUT-1:0] net_out = '0;
    logic                   sink_ready;
    logic                   dec_req = 1'b0;
    logic                   snk_valid;
    logic                   snk_ready = 1'b1;
    logic [SW-1:0]          snk;

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;
    logic [SW-1:0] exp_q[$];

    network_sink #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .arstn(arstn), .net_out_valid(net_out_valid), .net_out(net_out),
        .sink_ready(sink_ready), .dec_req(dec_req), .snk_valid(snk_valid),
        .snk_ready(snk_ready), .snk(snk)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] mkpkt(input int op, input int pay);
        logic [SW-1:0] p;
        p = SW'(op) << PW;
        p = p | SW'(pay);
        return p;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: a step emits SPK per fired output in index order, then TCK; count saturates.
    task automatic model_step(input logic [NET_NUM_OUT-1:0] m);
        for (int i = 0; i < NET_NUM_OUT; i++)
            if (m[i]) exp_q.push_back(mkpkt(1, i));
        exp_q.push_back(mkpkt(2, 0));
        if (model_cnt < CMAX) model_cnt++;
    endtask

    task automatic model_dec();
        exp_q.push_back(mkpkt(3, model_cnt));
        model_cnt = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound);
        int n;
        n = 0;
        while (!sink_ready && n < bound) begin
            step();
            n++;
        end
        if (!sink_ready) check("sink_ready_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || snk_valid || !sink_ready) && n < 400) begin
            step();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Capture one step (optionally with a coincident dec_req); exp_cyc>=0 checks
    // the number of edges after capture until sink_ready returns.
    task automatic capture(input logic [NET_NUM_OUT-1:0] m, input logic dec, input int exp_cyc);
        int n;
        logic v1;
        wait_ready(100);
        net_out_valid = 1'b1;
        net_out       = m;
        dec_req       = dec;
        model_step(m);
        if (dec) model_dec();
        step();
        net_out_valid = 1'b0;
        net_out       = '0;
        dec_req       = 1'b0;
        n  = 0;
        v1 = 1'b0;
        while (!sink_ready && n < 100) begin
            step();
            n++;
            if (n == 1) v1 = snk_valid;
        end
        if (exp_cyc >= 0) begin
            check("ready_return_cycles", n, exp_cyc);
            if (snk_ready) check("first_pkt_latency", int'(v1), 1);
        end
    endtask

    task automatic dec_pulse();
        wait_ready(100);
        dec_req = 1'b1;
        model_dec();
        step();
        dec_req = 1'b0;
    endtask

    // Monitor: compare each accepted packet; also check stability under backpressure.
    logic          stall_prev = 1'b0;
    logic [SW-1:0] snk_prev;
    always @(negedge clk) begin
        if (!arstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", int'(snk_valid), 1);
                check("hold_snk", int'(snk), int'(snk_prev));
            end
            if (snk_valid && snk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", int'(snk), -1);
                end else begin
                    logic [SW-1:0] e;
                    e = exp_q.pop_front();
                    check("pkt", int'(snk), int'(e));
                end
            end
            stall_prev = snk_valid && !snk_ready;
            snk_prev   = snk;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NET_NUM_OUT-1:0] m;
        int r;

        // reset
        #3;
        check("rst_snk_valid", int'(snk_valid), 0);
        check("rst_snk", int'(snk), 0);
        check("rst_sink_ready", int'(sink_ready), 1);
        step();
        arstn = 1'b1;
        repeat (5) step();
        check("post_rst_snk_valid", int'(snk_valid), 0);
        check("post_rst_sink_ready", int'(sink_ready), 1);

        // capture 1010 / empty step / backpressure on 0011
        capture(4'b1010, 1'b0, 3);
        drain();
        capture(4'b0000, 1'b0, 1);
        drain();
        snk_ready = 1'b0;
        capture(4'b0011, 1'b0, -1);
        repeat (2) step();
        check("bp_valid", int'(snk_valid), 1);
        check("bp_snk", int'(snk), int'(mkpkt(1, 0)));
        repeat (3) step();
        snk_ready = 1'b1;
        drain();

        // decode: DEC/3, DEC/0, coincident capture then DEC/1, merged pulses
        dec_pulse();
        drain();
        dec_pulse();
        drain();
        capture(4'b0101, 1'b1, -1);
        drain();
        wait_ready(100);
        dec_req = 1'b1;
        model_dec();
        step();
        step();
        dec_req = 1'b0;
        drain();

        // saturation
        for (int i = 0; i < 300; i++) capture('0, 1'b0, -1);
        drain();
        dec_pulse();
        drain();

        // reset mid-SCAN
        capture(4'b1111, 1'b0, -2);
        wait_ready(100);
        net_out_valid = 1'b1;
        net_out       = 4'b1111;
        model_step(4'b1111);
        step();
        net_out_valid = 1'b0;
        net_out       = '0;
        repeat (2) step();
        arstn = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = 0;
        check("midscan_rst_valid", int'(snk_valid), 0);
        check("midscan_rst_ready", int'(sink_ready), 1);
        step();
        arstn = 1'b1;
        repeat (8) step();
        check("post_midscan_valid", int'(snk_valid), 0);
        dec_pulse();
        drain();

        // randomized traffic with random backpressure and ignored garbage captures
        for (int c = 0; c < 1500; c++) begin
            snk_ready = ($urandom_range(3) != 0);
            net_out_valid = 1'b0;
            dec_req = 1'b0;
            if (sink_ready) begin
                r = $urandom_range(7);
                if (r < 4) begin
                    m = NET_NUM_OUT'($urandom);
                    net_out_valid = 1'b1;
                    net_out = m;
                    model_step(m);
                    if (r == 0) begin
                        dec_req = 1'b1;
                        model_dec();
                    end
                end else if (r == 4) begin
                    dec_req = 1'b1;
                    model_dec();
                end
            end else if ($urandom_range(3) == 0) begin
                net_out_valid = 1'b1;
                net_out = NET_NUM_OUT'($urandom);
            end
            step();
        end
        net_out_valid = 1'b0;
        dec_req = 1'b0;
        snk_ready = 1'b1;
        drain();
        dec_pulse();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
